// File: rtl/instr_pkg.sv
// Shared opcode constants and controller state encoding for the instruction memory.
package instr_pkg;

  // Opcode map of the small accumulator core this memory feeds.
  localparam int unsigned LDAC1 = 1;
  localparam int unsigned LDAC2 = 2;
  localparam int unsigned STAC1 = 3;
  localparam int unsigned STAC2 = 4;
  localparam int unsigned MVAC  = 5;
  localparam int unsigned MOVR  = 6;
  localparam int unsigned JUMP1 = 7;
  localparam int unsigned JUMP2 = 8;
  localparam int unsigned JMPZ1 = 9;
  localparam int unsigned JMPZ2 = 10;
  localparam int unsigned JPNZ1 = 11;
  localparam int unsigned JPNZ2 = 12;
  localparam int unsigned ADD   = 13;
  localparam int unsigned SUB   = 14;
  localparam int unsigned INAC  = 15;
  localparam int unsigned CLAC  = 16;
  localparam int unsigned AND   = 17;
  localparam int unsigned OR    = 18;
  localparam int unsigned XOR   = 19;
  localparam int unsigned NOT   = 20;
  localparam int unsigned MUL   = 21;
  localparam int unsigned SHL   = 22;
  localparam int unsigned SHR   = 23;
  localparam int unsigned LDI   = 24;
  localparam int unsigned HALT  = 25;
  localparam int unsigned NOP   = 26;
  localparam int unsigned NOP1  = 27;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/instr_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port, no array reset.
module instr_ram #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read; data holds when no read is issued.
  always_ff @(posedge clk) begin
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: streams a program in (LOAD), then serves
// latency-1 fetches (RUN), returning NOP_WORD beyond the loaded program.
// Optional per-word even parity is enabled by defining INSTR_MEM_PARITY_EN.
module instr_mem_ctrl
  import instr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NOP_WORD   = NOP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  input  logic                  fetch_en,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH:0]   prog_len,
  output logic                  run
`ifdef INSTR_MEM_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int unsigned LEN_W    = ADDR_WIDTH + 1;
  localparam int unsigned MAX_ADDR = (2 ** ADDR_WIDTH) - 1;
`ifdef INSTR_MEM_PARITY_EN
  localparam int unsigned MEM_W    = DATA_WIDTH + 1;
`else
  localparam int unsigned MEM_W    = DATA_WIDTH;
`endif

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_ld_ready;
  logic                  r_run;
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [LEN_W-1:0]      r_prog_len;
  logic                  r_instr_valid;
  logic                  r_use_nop;
  logic                  w_accept;
  logic                  w_fetch;
  logic                  w_clear;
  logic                  w_oob;
  logic [MEM_W-1:0]      w_wdata;
  logic [MEM_W-1:0]      w_rdata;

  // Fetch address at or past the program end reads as NOP.
  assign w_oob = {1'b0, fetch_addr} >= r_prog_len;

  // Next-state and per-cycle strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_fetch     = 1'b0;
    w_clear     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (load_start) begin
          w_state_nxt = ST_LOAD;
          w_clear     = 1'b1;
        end
      end
      ST_LOAD: begin
        w_accept = ld_valid;
        if (ld_valid && (ld_last || (r_wptr == ADDR_WIDTH'(MAX_ADDR))))
          w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (load_start) begin
          w_state_nxt = ST_LOAD;
          w_clear     = 1'b1;
        end else begin
          w_fetch = fetch_en;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register with state-decoded outputs registered alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ld_ready <= 1'b0;
      r_run      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ld_ready <= (w_state_nxt == ST_LOAD);
      r_run      <= (w_state_nxt == ST_RUN);
    end
  end

  // Write pointer, program length and fetch-result tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr        <= '0;
      r_prog_len    <= '0;
      r_instr_valid <= 1'b0;
      r_use_nop     <= 1'b1;
    end else begin
      if (w_clear) begin
        r_wptr     <= '0;
        r_prog_len <= '0;
      end else if (w_accept) begin
        r_wptr     <= r_wptr + ADDR_WIDTH'(1);
        r_prog_len <= r_prog_len + LEN_W'(1);
      end
      r_instr_valid <= w_fetch;
      if (w_fetch) r_use_nop <= w_oob;
    end
  end

`ifdef INSTR_MEM_PARITY_EN
  assign w_wdata    = {^ld_data, ld_data};
  // Even parity over data plus stored bit must reduce to zero.
  assign parity_err = r_instr_valid & ~r_use_nop & (^w_rdata);
`else
  assign w_wdata    = ld_data;
`endif

  instr_ram #(
    .WIDTH      (MEM_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (r_wptr),
    .i_wdata (w_wdata),
    .i_re    (w_fetch & ~w_oob),
    .i_raddr (fetch_addr),
    .o_rdata (w_rdata)
  );

  assign ld_ready    = r_ld_ready;
  assign run         = r_run;
  assign prog_len    = r_prog_len;
  assign instr_valid = r_instr_valid;
  assign instr       = r_use_nop ? DATA_WIDTH'(NOP_WORD) : w_rdata[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench for instr_mem_ctrl: vector table plus hand-written multi-cycle sequences.
// Define INSTR_MEM_PARITY_EN to also exercise the parity path.
`timescale 1ns/1ps
module tb_instr_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_start, ld_valid, ld_ready, ld_last, fetch_en;
  logic [7:0] ld_data, fetch_addr, instr;
  logic       instr_valid, run;
  logic [8:0] prog_len;
`ifdef INSTR_MEM_PARITY_EN
  logic       parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_mem_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .fetch_en    (fetch_en),
    .fetch_addr  (fetch_addr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .prog_len    (prog_len),
    .run         (run)
`ifdef INSTR_MEM_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  typedef struct {
    logic       ls;
    logic       vld;
    logic [7:0] d;
    logic       last;
    logic       fe;
    logic [7:0] fa;
    logic       e_rdy;
    logic       e_run;
    logic [8:0] e_len;
    logic       e_iv;
    logic [7:0] e_instr;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic ls, logic vld, logic [7:0] d, logic last,
                              logic fe, logic [7:0] fa, logic e_rdy, logic e_run,
                              logic [8:0] e_len, logic e_iv, logic [7:0] e_instr);
    vec_t v;
    v.ls = ls; v.vld = vld; v.d = d; v.last = last; v.fe = fe; v.fa = fa;
    v.e_rdy = e_rdy; v.e_run = e_run; v.e_len = e_len; v.e_iv = e_iv; v.e_instr = e_instr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ls, input logic vld, input logic [7:0] d,
                       input logic last, input logic fe, input logic [7:0] fa);
    load_start = ls; ld_valid = vld; ld_data = d; ld_last = last;
    fetch_en = fe; fetch_addr = fa;
  endtask

  // Apply the current inputs across one rising edge, sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_run", 32'(run), 32'd0);
    chk("rst_prog_len", 32'(prog_len), 32'd0);
    chk("rst_instr", 32'(instr), 32'd26);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
`ifdef INSTR_MEM_PARITY_EN
    chk("rst_parity_err", 32'(parity_err), 32'd0);
`endif
    rst = 1'b0;

    // ls vld d last fe fa | rdy run len iv instr
    vq.push_back(mk(0, 1, 8'h55, 1, 1, 8'h00, 0, 0, 9'd0, 0, 8'd26)); // IDLE ignores load/fetch
    vq.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 1, 0, 9'd0, 0, 8'd26)); // enter LOAD
    vq.push_back(mk(0, 1, 8'h03, 0, 0, 8'h00, 1, 0, 9'd1, 0, 8'd26));
    vq.push_back(mk(0, 0, 8'hEE, 0, 0, 8'h00, 1, 0, 9'd1, 0, 8'd26)); // bubble
    vq.push_back(mk(0, 1, 8'h1A, 0, 0, 8'h00, 1, 0, 9'd2, 0, 8'd26));
    vq.push_back(mk(0, 1, 8'h11, 1, 0, 8'h00, 0, 1, 9'd3, 0, 8'd26)); // last -> RUN
    vq.push_back(mk(0, 0, 8'h00, 0, 1, 8'd0,  0, 1, 9'd3, 1, 8'h03));
    vq.push_back(mk(0, 0, 8'h00, 0, 1, 8'd1,  0, 1, 9'd3, 1, 8'h1A));
    vq.push_back(mk(0, 0, 8'h00, 0, 1, 8'd2,  0, 1, 9'd3, 1, 8'h11));
    vq.push_back(mk(0, 0, 8'h00, 0, 0, 8'd0,  0, 1, 9'd3, 0, 8'h11)); // hold
    vq.push_back(mk(0, 0, 8'h00, 0, 1, 8'd5,  0, 1, 9'd3, 1, 8'd26)); // beyond program
    vq.push_back(mk(0, 0, 8'h00, 0, 1, 8'd3,  0, 1, 9'd3, 1, 8'd26)); // addr == prog_len
    vq.push_back(mk(0, 0, 8'h00, 0, 1, 8'd2,  0, 1, 9'd3, 1, 8'h11)); // addr == prog_len-1
    vq.push_back(mk(1, 0, 8'h00, 0, 1, 8'd0,  1, 0, 9'd0, 0, 8'h11)); // load_start beats fetch
    vq.push_back(mk(0, 0, 8'h00, 0, 1, 8'd0,  1, 0, 9'd0, 0, 8'h11)); // fetch ignored in LOAD
    vq.push_back(mk(1, 1, 8'h05, 0, 0, 8'd0,  1, 0, 9'd1, 0, 8'h11)); // load_start ignored in LOAD
    vq.push_back(mk(0, 1, 8'h07, 1, 0, 8'd0,  0, 1, 9'd2, 0, 8'h11));
    vq.push_back(mk(0, 0, 8'h00, 0, 1, 8'd1,  0, 1, 9'd2, 1, 8'h07));
    vq.push_back(mk(0, 0, 8'h00, 0, 1, 8'd2,  0, 1, 9'd2, 1, 8'd26));
    vq.push_back(mk(0, 0, 8'h00, 0, 1, 8'd0,  0, 1, 9'd2, 1, 8'h05));

    foreach (vq[i]) begin
      drive(vq[i].ls, vq[i].vld, vq[i].d, vq[i].last, vq[i].fe, vq[i].fa);
      step();
      chk($sformatf("v%0d_ld_ready", i), 32'(ld_ready), 32'(vq[i].e_rdy));
      chk($sformatf("v%0d_run", i), 32'(run), 32'(vq[i].e_run));
      chk($sformatf("v%0d_prog_len", i), 32'(prog_len), 32'(vq[i].e_len));
      chk($sformatf("v%0d_instr_valid", i), 32'(instr_valid), 32'(vq[i].e_iv));
      chk($sformatf("v%0d_instr", i), 32'(instr), 32'(vq[i].e_instr));
    end

    // Full-depth load with no ld_last: auto transition on the last address.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step();
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b1, 8'(i) ^ 8'hA5, 1'b0, 1'b0, 8'h00);
      step();
      if (i == 254) begin
        chk("full_len255", 32'(prog_len), 32'd255);
        chk("full_run_before_last", 32'(run), 32'd0);
        chk("full_ready_before_last", 32'(ld_ready), 32'd1);
      end
    end
    chk("full_len256", 32'(prog_len), 32'd256);
    chk("full_run", 32'(run), 32'd1);
    chk("full_ld_ready", 32'(ld_ready), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0);
    step();
    chk("full_fetch0", 32'(instr), 32'hA5);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'd255);
    step();
    chk("full_fetch255", 32'(instr), 32'h5A);
    chk("full_fetch255_valid", 32'(instr_valid), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'd128);
    step();
    chk("full_fetch128", 32'(instr), 32'h25);

    // Reset in the middle of a load.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step();
    drive(1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 8'h00);
    step();
    drive(1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 8'h00);
    step();
    chk("midrst_len_before", 32'(prog_len), 32'd2);
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_run", 32'(run), 32'd0);
    chk("midrst_ld_ready", 32'(ld_ready), 32'd0);
    chk("midrst_prog_len", 32'(prog_len), 32'd0);
    chk("midrst_instr", 32'(instr), 32'd26);
    chk("midrst_instr_valid", 32'(instr_valid), 32'd0);
    // Stale word at address 1 must stay unreachable after a one-word reload.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step();
    drive(1'b0, 1'b1, 8'h99, 1'b1, 1'b0, 8'h00);
    step();
    chk("reload_len", 32'(prog_len), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'd1);
    step();
    chk("reload_fetch1", 32'(instr), 32'd26);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0);
    step();
    chk("reload_fetch0", 32'(instr), 32'h99);

`ifdef INSTR_MEM_PARITY_EN
    // Corrupt the stored parity bit of address 1 and fetch it.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step();
    drive(1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 8'h00);
    step();
    drive(1'b0, 1'b1, 8'h1A, 1'b0, 1'b0, 8'h00);
    step();
    drive(1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 8'h00);
    step();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'd1);
    step();
    chk("par_clean", 32'(parity_err), 32'd0);
    dut.u_ram.r_mem[1][8] = ~dut.u_ram.r_mem[1][8];
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'd1);
    step();
    chk("par_err", 32'(parity_err), 32'd1);
    chk("par_err_valid", 32'(instr_valid), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0);
    step();
    chk("par_other_addr", 32'(parity_err), 32'd0);
`endif

    idle_inputs();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_ctrl.md
INSTR_MEM_CTRL -- requirements
Module: instr_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning instruction word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning address width; depth = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter NOP_WORD, default 26, meaning the word returned for fetches at or beyond the loaded program.
REQ-004 SHALL use one clock, clk, with a synchronous active-high reset, rst.
REQ-005 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  sync active-high reset.
- load_start  in  1  pulse; begin program load.
- ld_valid  in  1  load word valid.
- ld_ready  out  1  load word accepted when ld_valid & ld_ready.
- ld_data  in  DATA_WIDTH  load word.
- ld_last  in  1  final word of program.
- fetch_en  in  1  fetch request.
- fetch_addr  in  ADDR_WIDTH  fetch address.
- instr  out  DATA_WIDTH  fetched word.
- instr_valid  out  1  instr holds a fetch result.
- prog_len  out  ADDR_WIDTH+1  words loaded.
- run  out  1  high in RUN state.

Function
REQ-006 SHALL implement FSM IDLE, LOAD, RUN.
REQ-007 SHALL go from IDLE or RUN to LOAD on load_start, clearing write pointer and prog_len in the same edge.
REQ-008 SHALL ignore load_start while in LOAD.
REQ-009 SHALL drive ld_ready = 1 only in LOAD.
REQ-010 SHALL, on each accepted word, write ld_data at the write pointer, increment the pointer, and increment prog_len.
REQ-011 SHALL go LOAD -> RUN on an accepted word with ld_last = 1, or on an accepted word at address 2**ADDR_WIDTH-1, whichever is first; prog_len then equals 2**ADDR_WIDTH.
REQ-012 SHALL, in RUN with fetch_en = 1, present the word at fetch_addr on instr one cycle later with instr_valid = 1 (read latency 1).
REQ-013 SHALL return NOP_WORD with instr_valid = 1 when fetch_addr >= prog_len.
REQ-014 SHALL hold instr and deassert instr_valid in any cycle following no fetch; fetch_en SHALL be ignored outside RUN.
REQ-015 SHALL give load_start priority over a simultaneous fetch_en in RUN: no instr_valid on the next cycle.
REQ-016 SHALL assert run = 1 exactly while the state is RUN.

Reset
REQ-017 SHALL, on rst, set state IDLE, write pointer 0, prog_len 0, instr = NOP_WORD, instr_valid 0, ld_ready 0, run 0.
REQ-018 SHALL NOT clear memory contents on rst; a reset during LOAD abandons the load, and words already written remain but are unreachable, since prog_len is 0.

Configuration
REQ-019 SHALL, with INSTR_MEM_PARITY_EN defined, store one even-parity bit per word, check it on every fetch, and add output parity_err (1 bit, asserted together with instr_valid on a mismatch; 0 after reset).
REQ-020 SHALL, without INSTR_MEM_PARITY_EN, have no parity storage and no parity_err port.

Structure
REQ-021 SHALL take opcode constants (LDAC1..NOP1, including NOP = 26) and the FSM state typedef from shared package instr_pkg.
REQ-022 SHALL instantiate one sub-module, instr_ram: a simple dual-port synchronous RAM with a registered read and no reset on the array.

Verification
REQ-023 Reset then load_start, load 3 words 0x03,0x1A,0x11 with ld_last on the third -> prog_len = 3, run = 1.
REQ-024 In RUN, fetch addresses 0,1,2 on consecutive cycles -> instr = 0x03,0x1A,0x11 on the following cycles, instr_valid = 1 each.
REQ-025 Fetch address 5 with prog_len = 3 -> instr = 26, instr_valid = 1.
REQ-026 Load 256 words without ld_last (ADDR_WIDTH = 8) -> automatic RUN, prog_len = 256, ld_ready = 0.
REQ-027 Assert rst mid-LOAD after 2 words -> next cycle state IDLE, prog_len = 0, instr = 26, instr_valid = 0.
REQ-028 With INSTR_MEM_PARITY_EN, force a stored parity bit flip at address 1, then fetch address 1 -> parity_err = 1 with instr_valid = 1.
